// File: rtl/fb_pkg.sv
// Shared framebuffer widths, coordinate/colour types and the fill sequencer states.
// Also holds the small min/max/clip helpers used by rectangle normalisation.
package fb_pkg;

    localparam int FB_COORD_W = 6;
    localparam int FB_COLOR_W = 4;

    typedef logic [FB_COORD_W-1:0] coord_t;
    typedef logic [FB_COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } fb_state_e;

    function automatic coord_t coord_min(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t coord_max(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic coord_t coord_clip(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fb_fill_walker.sv
// Rectangle normalisation/clipping and the x/y raster counters of the fill engine.
// Counters load on load_i and advance one pixel per cycle while run_i is high and hold_i is low.
module fb_fill_walker
    import fb_pkg::*;
#(
    parameter int FB_COLS = 40,
    parameter int FB_ROWS = 20
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   run_i,
    input  logic   hold_i,
    input  coord_t x0_i,
    input  coord_t y0_i,
    input  coord_t x1_i,
    input  coord_t y1_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   last_o,
    output logic   empty_o
);

    localparam coord_t MAX_X = coord_t'(FB_COLS - 1);
    localparam coord_t MAX_Y = coord_t'(FB_ROWS - 1);

    coord_t xa_c, xb_c, ya_c, yb_c;
    coord_t xa_q, xa_d, xb_q, xb_d, yb_q, yb_d;
    coord_t x_q, x_d, y_q, y_d;

    // Only the far corners need clipping; a near corner past the edge makes the fill empty.
    always_comb begin
        xa_c    = coord_min(x0_i, x1_i);
        ya_c    = coord_min(y0_i, y1_i);
        xb_c    = coord_clip(coord_max(x0_i, x1_i), MAX_X);
        yb_c    = coord_clip(coord_max(y0_i, y1_i), MAX_Y);
        empty_o = (xa_c > MAX_X) || (ya_c > MAX_Y);
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        xa_d = xa_q;
        xb_d = xb_q;
        yb_d = yb_q;
        x_d  = x_q;
        y_d  = y_q;
        if (load_i) begin
            xa_d = xa_c;
            xb_d = xb_c;
            yb_d = yb_c;
            x_d  = xa_c;
            y_d  = ya_c;
        end else if (run_i && !hold_i) begin
            if (x_q == xb_q) begin
                x_d = xa_q;
                y_d = y_q + 6'd1;
            end else begin
                x_d = x_q + 6'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa_q <= '0;
            xb_q <= '0;
            yb_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            xa_q <= xa_d;
            xb_q <= xb_d;
            yb_q <= yb_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == xb_q) && (y_q == yb_q);

endmodule

// File: rtl/fb_fill_arbiter.sv
// Merges CPU pixel writes (fixed priority) with the rectangle-fill engine onto the framebuffer
// update port, and holds CPU LCD refresh requests until no fill is in progress.
module fb_fill_arbiter
    import fb_pkg::*;
#(
    parameter int FB_COLS = 40,
    parameter int FB_ROWS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FB_COORD_W-1:0] cpu_x,
    input  logic [FB_COORD_W-1:0] cpu_y,
    input  logic [FB_COLOR_W-1:0] cpu_data,
    input  logic                  cpu_enable,
    input  logic [FB_COORD_W-1:0] fill_x0,
    input  logic [FB_COORD_W-1:0] fill_y0,
    input  logic [FB_COORD_W-1:0] fill_x1,
    input  logic [FB_COORD_W-1:0] fill_y1,
    input  logic [FB_COLOR_W-1:0] fill_color,
    input  logic                  fill_start,
    output logic                  fill_busy,
    output logic                  fill_done,
    input  logic                  lcd_ready,
    input  logic                  lcd_update_req,
    output logic                  lcd_update,
    output logic [FB_COORD_W-1:0] fb_x_update,
    output logic [FB_COORD_W-1:0] fb_y_update,
    output logic [FB_COLOR_W-1:0] fb_data_update,
    output logic                  fb_enable_update
);

    fb_state_e state_q, state_d;
    color_t    color_q, color_d;
    coord_t    fb_x_q, fb_x_d, fb_y_q, fb_y_d;
    color_t    fb_data_q, fb_data_d;
    logic      fb_en_q, fb_en_d;
    logic      busy_q, done_q, lcd_q, lcd_d;
    logic      pending_q, pending_d;
    logic      start_ok;
    coord_t    walk_x, walk_y;
    logic      walk_last, walk_empty;

    assign start_ok = fill_start && (state_q == IDLE);

    fb_fill_walker #(
        .FB_COLS(FB_COLS),
        .FB_ROWS(FB_ROWS)
    ) u_walker (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_ok),
        .run_i  (state_q == FILL),
        .hold_i (cpu_enable),
        .x0_i   (fill_x0),
        .y0_i   (fill_y0),
        .x1_i   (fill_x1),
        .y1_i   (fill_y1),
        .x_o    (walk_x),
        .y_o    (walk_y),
        .last_o (walk_last),
        .empty_o(walk_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = walk_empty ? FLUSH : FILL;
            FILL:    if (!cpu_enable && walk_last) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        color_d   = start_ok ? fill_color : color_q;
        fb_x_d    = fb_x_q;
        fb_y_d    = fb_y_q;
        fb_data_d = fb_data_q;
        fb_en_d   = 1'b0;
        if (cpu_enable) begin
            fb_x_d    = cpu_x;
            fb_y_d    = cpu_y;
            fb_data_d = cpu_data;
            fb_en_d   = 1'b1;
        end else if (state_q == FILL) begin
            fb_x_d    = walk_x;
            fb_y_d    = walk_y;
            fb_data_d = color_q;
            fb_en_d   = 1'b1;
        end
    end

    // Refresh fires when the sequencer is about to be idle; a request arriving while an older
    // one is being served is kept for a second pulse rather than merged into this one.
    always_comb begin
        lcd_d     = (pending_q || lcd_update_req) && lcd_ready && (state_d == IDLE);
        pending_d = lcd_d ? (pending_q && lcd_update_req) : (pending_q || lcd_update_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            color_q   <= '0;
            fb_x_q    <= '0;
            fb_y_q    <= '0;
            fb_data_q <= '0;
            fb_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lcd_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            color_q   <= color_d;
            fb_x_q    <= fb_x_d;
            fb_y_q    <= fb_y_d;
            fb_data_q <= fb_data_d;
            fb_en_q   <= fb_en_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FLUSH);
            lcd_q     <= lcd_d;
            pending_q <= pending_d;
        end
    end

    assign fill_busy        = busy_q;
    assign fill_done        = done_q;
    assign lcd_update       = lcd_q;
    assign fb_x_update      = fb_x_q;
    assign fb_y_update      = fb_y_q;
    assign fb_data_update   = fb_data_q;
    assign fb_enable_update = fb_en_q;

endmodule
